// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side capture inputs, register-file write port,
// WB forwarding source, ID-stage bypass and retired-instruction count.
interface mem_wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             en;
    logic             flush;
    logic             valid_mem;
    logic [XLEN-1:0]  alu_result_for_wb;
    logic [XLEN-1:0]  load_wb_data;
    logic [4:0]       rd_for_wb;
    logic             wb_reg_file_out;
    logic             memtoreg_out;
    logic [4:0]       rs1_addr_id;
    logic [4:0]       rs2_addr_id;
    logic [XLEN-1:0]  rf_rs1_data;
    logic [XLEN-1:0]  rf_rs2_data;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             fwd_wb_en;
    logic [4:0]       fwd_wb_rd;
    logic [XLEN-1:0]  fwd_wb_data;
    logic [XLEN-1:0]  rs1_data_id;
    logic [XLEN-1:0]  rs2_data_id;
    logic [CNT_W-1:0] instret;

    modport master (
        output en, flush, valid_mem, alu_result_for_wb, load_wb_data, rd_for_wb,
               wb_reg_file_out, memtoreg_out, rs1_addr_id, rs2_addr_id,
               rf_rs1_data, rf_rs2_data,
        input  rf_we, rf_waddr, rf_wdata, fwd_wb_en, fwd_wb_rd, fwd_wb_data,
               rs1_data_id, rs2_data_id, instret
    );

    modport slave (
        input  en, flush, valid_mem, alu_result_for_wb, load_wb_data, rd_for_wb,
               wb_reg_file_out, memtoreg_out, rs1_addr_id, rs2_addr_id,
               rf_rs1_data, rf_rs2_data,
        output rf_we, rf_waddr, rf_wdata, fwd_wb_en, fwd_wb_rd, fwd_wb_data,
               rs1_data_id, rs2_data_id, instret
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: captures MEM results under
// stall/flush, drives the register-file write port, WB forwarding, ID bypass and instret.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);
    logic             valid_q,    valid_d;
    logic             wb_q,       wb_d;
    logic             memtoreg_q, memtoreg_d;
    logic [4:0]       rd_q,       rd_d;
    logic [XLEN-1:0]  alu_q,      alu_d;
    logic [XLEN-1:0]  load_q,     load_d;
    logic [CNT_W-1:0] instret_q,  instret_d;

    logic             we;
    logic [XLEN-1:0]  wdata;
    logic             retire;

    // Flush wins over stall; a stalled edge neither captures nor counts.
    assign retire = !bus.flush && bus.en && bus.valid_mem;

    always_comb begin
        valid_d    = valid_q;
        wb_d       = wb_q;
        memtoreg_d = memtoreg_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        load_d     = load_q;
        if (bus.flush) begin
            valid_d    = 1'b0;
            wb_d       = 1'b0;
            memtoreg_d = 1'b0;
            rd_d       = 5'd0;
            alu_d      = '0;
            load_d     = '0;
        end else if (bus.en) begin
            valid_d    = bus.valid_mem;
            wb_d       = bus.wb_reg_file_out;
            memtoreg_d = bus.memtoreg_out;
            rd_d       = bus.rd_for_wb;
            alu_d      = bus.alu_result_for_wb;
            load_d     = bus.load_wb_data;
        end
    end

    // Wraps silently modulo 2^CNT_W.
    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            wb_q       <= 1'b0;
            memtoreg_q <= 1'b0;
            rd_q       <= 5'd0;
            alu_q      <= '0;
            load_q     <= '0;
            instret_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            wb_q       <= wb_d;
            memtoreg_q <= memtoreg_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            load_q     <= load_d;
            instret_q  <= instret_d;
        end
    end

    // x0 is never written, so address 0 can never hit the ID bypass either.
    assign we    = valid_q && wb_q && (rd_q != 5'd0);
    assign wdata = memtoreg_q ? load_q : alu_q;

    assign bus.rf_we       = we;
    assign bus.rf_waddr    = rd_q;
    assign bus.rf_wdata    = wdata;
    assign bus.fwd_wb_en   = we;
    assign bus.fwd_wb_rd   = rd_q;
    assign bus.fwd_wb_data = wdata;
    assign bus.instret     = instret_q;

    assign bus.rs1_data_id = (we && bus.rs1_addr_id == rd_q) ? wdata : bus.rf_rs1_data;
    assign bus.rs2_data_id = (we && bus.rs2_addr_id == rd_q) ? wdata : bus.rf_rs2_data;
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback stage of the 5-stage RV32 core, directly downstream of the MEM stage. Captures the MEM stage's outputs under stall/flush control, selects the writeback value (ALU result vs. load data), and drives the register-file write port. It also drives the WB→EX forwarding source, the register-file write-through bypass for ID-stage reads, and the 64-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath width
CNT_W, 64, retired-instruction counter width

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  1 = advance pipeline register; 0 = hold (stall)
flush  input  1  1 = load a bubble into the register
valid_mem  input  1  MEM stage holds a real instruction
alu_result_for_wb  input  XLEN  ALU value from MEM stage
load_wb_data  input  XLEN  extended load data from MEM stage
rd_for_wb  input  5  destination register
wb_reg_file_out  input  1  instruction writes the register file
memtoreg_out  input  1  1 = write load data, 0 = write ALU value
rs1_addr_id  input  5  ID-stage read address 1
rs2_addr_id  input  5  ID-stage read address 2
rf_rs1_data  input  XLEN  raw register-file read data 1
rf_rs2_data  input  XLEN  raw register-file read data 2
rf_we  output  1  register-file write enable
rf_waddr  output  5  register-file write address
rf_wdata  output  XLEN  register-file write data
fwd_wb_en  output  1  WB forwarding source valid (equals rf_we)
fwd_wb_rd  output  5  WB forwarding destination (equals rf_waddr)
fwd_wb_data  output  XLEN  WB forwarding data (equals rf_wdata)
rs1_data_id  output  XLEN  bypassed read data 1 to ID
rs2_data_id  output  XLEN  bypassed read data 2 to ID
instret  output  CNT_W  retired-instruction count

Behaviour:
- Registered state:
  - valid_q, wb_q, memtoreg_q, rd_q, alu_q, load_q.
  - instret counter.
- Reset (rst=0, asynchronous): all registers go to 0. Consequences: rf_we=0, rf_waddr=0, rf_wdata=0, fwd_* all 0, instret=0. Reset mid-stall discards the held instruction.
- Register update priority per clock edge:
  1. flush=1: valid_q=0 and wb_q=0; other fields are don't-care and are cleared to 0. Flush wins over en=0.
  2. else en=1: capture all inputs; valid_q=valid_mem.
  3. else (en=0): hold all fields.
- Latency: MEM-stage values appear on rf_* one cycle after the capturing edge.
- Writeback (combinational from registers):
  - rf_we = valid_q & wb_q & (rd_q != 0). Writes to x0 are never asserted.
  - rf_waddr = rd_q.
  - rf_wdata = memtoreg_q ? load_q : alu_q.
  - fwd_* mirror rf_* exactly.
- Stall behaviour: a held instruction keeps rf_we asserted every stalled cycle. Rewriting the same value is architecturally harmless and is permitted.
- ID bypass: rs1_data_id = (rf_we && rs1_addr_id == rf_waddr) ? rf_wdata : rf_rs1_data. Same rule for rs2. Address 0 never bypasses, because rf_we=0 when rd_q=0.
- instret:
  - Increments by 1 on an edge where flush=0, en=1 and valid_mem=1, i.e. once per instruction entering WB. A stall never double-counts.
  - Counts instructions with and without register writes (stores, branches).
  - Wraps modulo 2^CNT_W to 0 with no flag.
- en is don't-care while flush=1.

Test Plan:
- Reset, then release with en=1 and valid_mem=1, rd=5, wb=1, memtoreg=0, alu=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234, instret=1.
- Load path: memtoreg=1, load=0xFFFFFF80, alu=0x100, rd=7 → rf_wdata=0xFFFFFF80. Same instruction with rd=0 → rf_we=0, fwd_wb_en=0, instret still increments.
- Stall: capture rd=3, then en=0 for 3 cycles with new inputs applied → rf_* hold rd=3 data for all 3 cycles; instret increases by 1 total.
- Flush vs stall: flush=1 and en=0 on the same edge while an instruction is held → rf_we=0 next cycle, instret unchanged.
- Bypass: WB writing x9=0xDEADBEEF, rs1_addr_id=9, rf_rs1_data=0 → rs1_data_id=0xDEADBEEF. rs2_addr_id=10, rf_rs2_data=0x55 → rs2_data_id=0x55.
- Async reset mid-operation: assert rst=0 between clock edges while rf_we=1 → outputs clear immediately, before the next edge. Force instret to 0xFFFF_FFFF_FFFF_FFFF, retire one instruction → instret=0.
